// File: rtl/fetch_stage_pkg.sv
// Shared widths, defaults and the buffered fetch entry type
// used by the fetch stage and its instruction buffer.
package fetch_stage_pkg;

    localparam int XLEN = 32;
    localparam int INSTR_LEN = 32;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam int FETCH_BUF_DEPTH = 2;

    typedef struct packed {
        logic [INSTR_LEN-1:0] instr;
        logic [XLEN-1:0]      pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_buffer.sv
// Two-entry instruction FIFO between imem response and decode.
// Flush clears pointers and count; stored words are left as-is.
module fetch_buffer
    import fetch_stage_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  fetch_entry_t wdata,
    output fetch_entry_t head,
    output logic [1:0]   count
);

    fetch_entry_t mem [FETCH_BUF_DEPTH];
    logic         head_ptr;
    logic         tail_ptr;

    // Pointer and occupancy update; flush beats push and pop
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            head_ptr <= 1'b0;
            tail_ptr <= 1'b0;
            count    <= 2'd0;
        end else begin
            if (push) begin
                tail_ptr <= ~tail_ptr;
            end
            if (pop) begin
                head_ptr <= ~head_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // Storage write at the tail slot
    always_ff @(posedge clk) begin
        if (rst_n && push && !flush) begin
            mem[tail_ptr] <= wdata;
        end
    end

    assign head = mem[head_ptr];

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC, request issue, redirect flush, and
// valid/ready delivery of {instr, pc} to decode.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC  = RESET_PC_DEFAULT,
    parameter int              BUF_DEPTH = FETCH_BUF_DEPTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    output logic                 imem_req,
    output logic [XLEN-1:0]      imem_addr,
    input  logic [INSTR_LEN-1:0] imem_rdata,
    input  logic                 redirect_valid,
    input  logic [XLEN-1:0]      redirect_pc,
    output logic                 instr_valid,
    input  logic                 instr_ready,
    output logic [INSTR_LEN-1:0] instr,
    output logic [XLEN-1:0]      instr_pc
);

    logic [XLEN-1:0] pc;
    logic            in_flight;
    logic [XLEN-1:0] in_flight_pc;
    logic            drop;
    logic            pop;
    logic            push;
    logic [1:0]      count;
    logic [2:0]      occ;
    logic [XLEN-1:0] target;
    fetch_entry_t    head;
    fetch_entry_t    wdata;

    // Reserved for a multi-cycle memory; a redirect never
    // leaves a request outstanding here.
    assign drop = 1'b0;

    assign target = redirect_pc & ~XLEN'(3);

    assign instr_valid = rst_n && (count != 2'd0);
    assign pop = instr_valid && instr_ready;

    // Slots that would be taken after this cycle's pop
    assign occ = {1'b0, count} + {2'b00, in_flight}
               - {2'b00, pop};

    assign imem_req = rst_n && !redirect_valid
                    && (occ < 3'(BUF_DEPTH));
    assign imem_addr = pc;

    assign push = in_flight && !drop && !redirect_valid;
    assign wdata = '{instr: imem_rdata, pc: in_flight_pc};

    assign instr = head.instr;
    assign instr_pc = head.pc;

    // PC and outstanding-request tracking
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc           <= RESET_PC;
            in_flight    <= 1'b0;
            in_flight_pc <= '0;
        end else if (redirect_valid) begin
            pc        <= target;
            in_flight <= 1'b0;
        end else begin
            in_flight <= imem_req;
            if (imem_req) begin
                in_flight_pc <= pc;
                pc           <= pc + XLEN'(4);
            end
        end
    end

    fetch_buffer u_buf (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .flush (redirect_valid),
        .wdata (wdata),
        .head  (head),
        .count (count)
    );

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: queue-level reference model checked
// every cycle, plus directed scenarios with literal expectations.
module tb_fetch_stage;
    import fetch_stage_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata = 32'h0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [31:0] instr;
    logic [31:0] instr_pc;

    localparam logic [31:0] PAT = 32'hA5A5_0000;

    always #5 clk = ~clk;

    fetch_stage #(
        .RESET_PC  (32'h0),
        .BUF_DEPTH (2)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
        .instr_pc       (instr_pc)
    );

    // Synchronous memory: data one cycle after a request
    always @(posedge clk) begin
        imem_rdata <= imem_req ? (imem_addr ^ PAT) : 32'hDEAD_BEEF;
    end

    int npass = 0;
    int ntot = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        ntot++;
        if (act === exp) npass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Reference model state: PCs buffered, one outstanding read
    logic [31:0] mq[$];
    bit          m_out = 1'b0;
    logic [31:0] m_out_pc = 32'h0;
    logic [31:0] m_pc = 32'h0;
    bit          en = 1'b0;
    int          ncyc = 0;

    logic [31:0] req_log[$];
    logic [31:0] del_log[$];
    int          del_cyc[$];

    always @(negedge clk) begin
        bit ve;
        bit pe;
        bit re;
        int occ;
        ncyc++;
        if (en) begin
            ve = rst_n && (mq.size() > 0);
            pe = ve && instr_ready;
            occ = mq.size() + int'(m_out) - int'(pe);
            re = rst_n && !redirect_valid && (occ < 2);
            check("imem_req", 32'(imem_req), 32'(re));
            check("instr_valid", 32'(instr_valid), 32'(ve));
            if (rst_n) check("imem_addr", imem_addr, m_pc);
            if (ve) begin
                check("instr", instr, mq[0] ^ PAT);
                check("instr_pc", instr_pc, mq[0]);
            end
            if (imem_req) req_log.push_back(imem_addr);
            if (instr_valid && instr_ready) begin
                del_log.push_back(instr_pc);
                del_cyc.push_back(ncyc);
            end
            if (!rst_n) begin
                mq.delete();
                m_out = 1'b0;
                m_pc = 32'h0;
            end else if (redirect_valid) begin
                mq.delete();
                m_out = 1'b0;
                m_pc = redirect_pc & ~32'h3;
            end else begin
                if (pe) void'(mq.pop_front());
                if (m_out) begin
                    mq.push_back(m_out_pc);
                    check("no_overflow", 32'(mq.size() <= 2), 32'd1);
                end
                m_out = re;
                if (re) begin
                    m_out_pc = m_pc;
                    m_pc = m_pc + 32'd4;
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        req_log.delete();
        del_log.delete();
        del_cyc.delete();
    endtask

    task automatic check_del(input string name, input int idx,
                             input logic [31:0] exp);
        if (idx < del_log.size()) check(name, del_log[idx], exp);
        else check(name, 32'hFFFF_FFFF, exp ^ 32'h1);
    endtask

    task automatic check_req(input string name, input int idx,
                             input logic [31:0] exp);
        if (idx < req_log.size()) check(name, req_log[idx], exp);
        else check(name, 32'hFFFF_FFFF, exp ^ 32'h1);
    endtask

    int          mark;
    logic [31:0] last_req;

    initial begin
        @(posedge clk);
        #1;
        en = 1'b1;
        step(2);
        check("reset_req", 32'(imem_req), 32'd0);
        check("reset_valid", 32'(instr_valid), 32'd0);

        // T1: release with decode always ready
        instr_ready = 1'b1;
        clear_logs();
        rst_n = 1'b1;
        mark = ncyc;
        step(8);
        for (int i = 0; i < 4; i++) check_req("t1_addr", i, 32'(i * 4));
        check("t1_ndel", 32'(del_log.size()), 32'd6);
        if (del_cyc.size() > 0) check("t1_first_lat", 32'(del_cyc[0] - mark), 32'd3);
        else check("t1_first_lat", 32'hFFFF_FFFF, 32'd3);
        for (int i = 0; i < 4; i++) check_del("t1_pc", i, 32'(i * 4));
        for (int i = 1; i < del_cyc.size(); i++)
            check("t1_gap", 32'(del_cyc[i] - del_cyc[i-1]), 32'd1);

        // T2: stall decode from release
        rst_n = 1'b0;
        instr_ready = 1'b0;
        step(2);
        clear_logs();
        rst_n = 1'b1;
        step(6);
        check("t2_valid", 32'(instr_valid), 32'd1);
        check("t2_pc", instr_pc, 32'h0);
        check("t2_instr", instr, 32'hA5A5_0000);
        check("t2_req_idle", 32'(imem_req), 32'd0);
        check("t2_nreq", 32'(req_log.size()), 32'd2);
        check("t2_ndel", 32'(del_log.size()), 32'd0);
        clear_logs();
        instr_ready = 1'b1;
        mark = ncyc;
        step(5);
        for (int i = 0; i < 3; i++) check_del("t2_pc_seq", i, 32'(i * 4));
        for (int i = 0; i < 3 && i < del_cyc.size(); i++)
            check("t2_cyc", 32'(del_cyc[i] - mark), 32'(i + 1));

        // T3: one-cycle redirect while streaming
        step(3);
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_1003;
        step(1);
        redirect_valid = 1'b0;
        check("t3_valid_drop", 32'(instr_valid), 32'd0);
        clear_logs();
        step(6);
        check_req("t3_first_req", 0, 32'h0000_1000);
        for (int i = 0; i < 4; i++) check_del("t3_pc", i, 32'h1000 + 32'(i * 4));

        // T4: redirect meets a returning response and a pop
        last_req = req_log[$];
        check("t4_pop_valid", 32'(instr_valid), 32'd1);
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_2000;
        clear_logs();
        step(1);
        redirect_valid = 1'b0;
        step(6);
        check_del("t4_popped", 0, last_req - 32'd4);
        check_del("t4_target", 1, 32'h0000_2000);

        // T5: PC wrap through the top of the address space
        redirect_valid = 1'b1;
        redirect_pc = 32'hFFFF_FFF8;
        step(1);
        redirect_valid = 1'b0;
        clear_logs();
        step(6);
        check_del("t5_pc0", 0, 32'hFFFF_FFF8);
        check_del("t5_pc1", 1, 32'hFFFF_FFFC);
        check_del("t5_pc2", 2, 32'h0000_0000);
        check_req("t5_req_wrap", 2, 32'h0000_0000);

        // T6: one-cycle reset with a full buffer
        instr_ready = 1'b0;
        step(4);
        check("t6_full_valid", 32'(instr_valid), 32'd1);
        check("t6_full_idle", 32'(imem_req), 32'd0);
        rst_n = 1'b0;
        instr_ready = 1'b1;
        #1;
        check("t6_rst_valid", 32'(instr_valid), 32'd0);
        step(1);
        rst_n = 1'b1;
        #1;
        check("t6_valid_after", 32'(instr_valid), 32'd0);
        clear_logs();
        mark = ncyc;
        step(6);
        check_req("t6_req0", 0, 32'h0);
        check_del("t6_pc0", 0, 32'h0);
        check_del("t6_pc1", 1, 32'h4);
        if (del_cyc.size() > 0) check("t6_lat", 32'(del_cyc[0] - mark), 32'd3);
        else check("t6_lat", 32'hFFFF_FFFF, 32'd3);

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
